// File: rtl/dsd_decim.sv
// DSD bitstream to PCM: 3rd-order CIC decimator (R = 2^LOG2R), then rescale and saturate.
// Latency: pcm/pcm_valid register on the decimation strobe edge; valid is high the following cycle.
// No backpressure: one sample per R enabled bit strobes, pcm_valid is a single-cycle pulse.
module dsd_decim #(
    parameter int PCM_QUANT = 16,
    parameter int LOG2R     = 6
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        dsd_en,
    input  logic                        dsd,
    output logic signed [PCM_QUANT-1:0] pcm,
    output logic                        pcm_valid,
    output logic                        clip
);

    // Datapath width: three integrator stages of gain R each, plus sign and headroom.
    localparam int W  = 3 * LOG2R + 2;
    localparam int SH = W - 1 - PCM_QUANT;

    generate
        if ((3 * LOG2R + 1 < PCM_QUANT) || (LOG2R < 2)) begin : g_bad_params
            $error("dsd_decim: need 3*LOG2R+1 >= PCM_QUANT and LOG2R >= 2");
        end
    endgenerate

    // Saturation limits expressed at datapath width so compares stay signed.
    localparam logic signed [W-1:0] PMAX = {{(W-PCM_QUANT+1){1'b0}}, {(PCM_QUANT-1){1'b1}}};
    localparam logic signed [W-1:0] PMIN = {{(W-PCM_QUANT+1){1'b1}}, {(PCM_QUANT-1){1'b0}}};

    logic signed [W-1:0]         i1_q, i1_d, i2_q, i2_d, i3_q, i3_d;
    logic signed [W-1:0]         d1_q, d1_d, d2_q, d2_d, d3_q, d3_d;
    logic        [LOG2R-1:0]     cnt_q, cnt_d;
    logic        [1:0]           warm_q, warm_d;
    logic signed [PCM_QUANT-1:0] pcm_q, pcm_d;
    logic                        pcm_valid_q, pcm_valid_d;
    logic                        clip_q, clip_d;

    logic signed [W-1:0]         x, c1, c2, c3, s;
    logic signed [PCM_QUANT-1:0] sat_val;
    logic                        sat_clip;
    logic                        strobe;

    // Next-state: integrators on every enabled bit, combs and output only on the strobe.
    always_comb begin
        i1_d        = i1_q;
        i2_d        = i2_q;
        i3_d        = i3_q;
        d1_d        = d1_q;
        d2_d        = d2_q;
        d3_d        = d3_q;
        cnt_d       = cnt_q;
        warm_d      = warm_q;
        pcm_d       = pcm_q;
        clip_d      = clip_q;
        pcm_valid_d = 1'b0;

        // dsd=1 means a negative sample, matching the modulator polarity.
        x      = dsd ? {W{1'b1}} : {{(W-1){1'b0}}, 1'b1};
        strobe = dsd_en && (cnt_q == {LOG2R{1'b1}});

        // Comb chain on registered integrator output; modular wrap cancels here.
        c1 = i3_q - d1_q;
        c2 = c1 - d2_q;
        c3 = c2 - d3_q;

        // Full scale R^3 lands on 2^(PCM_QUANT-1), so +FS clips and -FS is exact.
        s = c3 >>> SH;
        if (s > PMAX) begin
            sat_val  = PMAX[PCM_QUANT-1:0];
            sat_clip = 1'b1;
        end else if (s < PMIN) begin
            sat_val  = PMIN[PCM_QUANT-1:0];
            sat_clip = 1'b1;
        end else begin
            sat_val  = s[PCM_QUANT-1:0];
            sat_clip = 1'b0;
        end

        if (dsd_en) begin
            i1_d  = i1_q + x;
            i2_d  = i2_q + i1_q;
            i3_d  = i3_q + i2_q;
            cnt_d = cnt_q + LOG2R'(1);
        end

        if (strobe) begin
            d1_d = i3_q;
            d2_d = c1;
            d3_d = c2;
            // First three strobes only prime the comb delays.
            if (warm_q == 2'd3) begin
                pcm_d       = sat_val;
                clip_d      = sat_clip;
                pcm_valid_d = 1'b1;
            end else begin
                warm_d = warm_q + 2'd1;
            end
        end
    end

    // State registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i1_q        <= '0;
            i2_q        <= '0;
            i3_q        <= '0;
            d1_q        <= '0;
            d2_q        <= '0;
            d3_q        <= '0;
            cnt_q       <= '0;
            warm_q      <= '0;
            pcm_q       <= '0;
            clip_q      <= 1'b0;
            pcm_valid_q <= 1'b0;
        end else begin
            i1_q        <= i1_d;
            i2_q        <= i2_d;
            i3_q        <= i3_d;
            d1_q        <= d1_d;
            d2_q        <= d2_d;
            d3_q        <= d3_d;
            cnt_q       <= cnt_d;
            warm_q      <= warm_d;
            pcm_q       <= pcm_d;
            clip_q      <= clip_d;
            pcm_valid_q <= pcm_valid_d;
        end
    end

    assign pcm       = pcm_q;
    assign pcm_valid = pcm_valid_q;
    assign clip      = clip_q;

endmodule

// File: tb/tb_dsd_decim.sv
// Directed bench for dsd_decim: reset, DC patterns, gated strobes, mid-frame reset.
// Expected values are hand-derived from the CIC DC gain R^3 = 2^18 scaled by 2^-3.
// Outputs sampled on the falling edge; inputs driven on the falling edge / #1 after rise.
module tb_dsd_decim;

    logic               clk = 1'b0;
    logic               rst_n;
    logic               dsd_en;
    logic               dsd;
    logic signed [15:0] pcm;
    logic               pcm_valid;
    logic               clip;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int base   = 0;

    int                 vt[$];
    logic signed [15:0] vp[$];
    logic               vc[$];
    logic signed [15:0] ref_seq[$];

    dsd_decim #(.PCM_QUANT(16), .LOG2R(6)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .dsd_en    (dsd_en),
        .dsd       (dsd),
        .pcm       (pcm),
        .pcm_valid (pcm_valid),
        .clip      (clip)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Record every valid sample with its cycle offset from the start of the run.
    always @(negedge clk) begin
        if (pcm_valid) begin
            vt.push_back(cyc - base);
            vp.push_back(pcm);
            vc.push_back(clip);
        end
    end

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst_n  = 1'b0;
        dsd_en = 1'b0;
        dsd    = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Drive ncyc clocks; pattern bits are consumed on enabled cycles only.
    task automatic run_pat(input logic [3:0] pat, input int plen, input bit gated,
                           input int ncyc);
        int  idx;
        bit  en;
        idx = 0;
        @(negedge clk);
        base = cyc;
        vt.delete();
        vp.delete();
        vc.delete();
        for (int k = 0; k < ncyc; k++) begin
            en     = !gated || (k % 2 == 0);
            dsd_en = en;
            if (en) begin
                dsd = pat[idx % plen];
                idx++;
            end else begin
                dsd = 1'($urandom_range(0, 1));
            end
            @(posedge clk);
            #1;
        end
        dsd_en = 1'b0;
    endtask

    task automatic chk_samples(input string tag, input int n_exp, input int first,
                               input int gap, input logic signed [15:0] val,
                               input logic clp);
        chk({tag, "_count"}, vt.size(), n_exp);
        if (vt.size() > 0) chk({tag, "_first"}, vt[0], first);
        for (int i = 1; i < vt.size(); i++) chk({tag, "_gap"}, vt[i] - vt[i-1], gap);
        for (int i = 0; i < vp.size(); i++) chk({tag, "_pcm"}, vp[i], val);
        for (int i = 0; i < vc.size(); i++) chk({tag, "_clip"}, vc[i], clp);
    endtask

    initial begin
        rst_n  = 1'b0;
        dsd_en = 1'b0;
        dsd    = 1'b0;
        // Inputs toggling while held in reset must not disturb the outputs.
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            dsd_en = 1'($urandom_range(0, 1));
            dsd    = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        chk("rst_pcm", pcm, 0);
        chk("rst_valid", pcm_valid, 0);
        chk("rst_clip", clip, 0);

        rst_n  = 1'b1;
        dsd_en = 1'b0;
        vt.delete();
        repeat (1000) begin
            @(posedge clk);
            #1 dsd = 1'($urandom_range(0, 1));
        end
        chk("idle_no_valid", vt.size(), 0);

        // Positive full scale saturates.
        do_reset();
        run_pat(4'b0000, 1, 1'b0, 460);
        chk_samples("const0", 4, 256, 64, 16'sd32767, 1'b1);

        // Negative full scale is exact.
        do_reset();
        run_pat(4'b0001, 1, 1'b0, 460);
        chk_samples("const1", 4, 256, 64, -16'sd32768, 1'b0);

        // Nyquist-rate alternation sits in a CIC null.
        do_reset();
        run_pat(4'b0010, 2, 1'b0, 460);
        chk_samples("alt", 4, 256, 64, 16'sd0, 1'b0);

        // Mean +0.5.
        do_reset();
        run_pat(4'b1000, 4, 1'b0, 460);
        chk_samples("p0001", 4, 256, 64, 16'sd16384, 1'b0);
        ref_seq = vp;

        // Mean -0.5.
        do_reset();
        run_pat(4'b1110, 4, 1'b0, 460);
        chk_samples("p0111", 4, 256, 64, -16'sd16384, 1'b0);

        // Half-rate enable: same samples, twice the spacing.
        do_reset();
        run_pat(4'b1000, 4, 1'b1, 800);
        chk_samples("gated", 3, 511, 128, 16'sd16384, 1'b0);
        for (int i = 0; i < vp.size() && i < ref_seq.size(); i++)
            chk("gated_seq", vp[i], ref_seq[i]);

        // Reset asserted at enabled count 30 of frame 6, away from any clock edge.
        do_reset();
        run_pat(4'b1000, 4, 1'b0, 350);
        chk("mid_pre_count", vt.size(), 2);
        chk("mid_pre_pcm", pcm, 16384);
        #3 rst_n = 1'b0;
        #1;
        chk("mid_rst_pcm", pcm, 0);
        chk("mid_rst_valid", pcm_valid, 0);
        chk("mid_rst_clip", clip, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        run_pat(4'b1000, 4, 1'b0, 300);
        chk_samples("mid_after", 1, 256, 64, 16'sd16384, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end

endmodule
